// File: rtl/spi_master.sv
// spi_master: single-clock SPI master for 10-bit command frames.
// A frame is a two-cycle select preamble, the 10-bit word sent LSB-first
// on MOSI and, for rd-data frames only, a turnaround followed by an 8-bit
// MSB-first read-back on MISO. Every frame ends with a minimum SS_n-high gap.
// The slave runs on the same clk, so all timing is counted in clk cycles.
module spi_master #(
    parameter int RD_LAT = 3,  // idle cycles between last MOSI bit and first MISO sample, 1..15
    parameter int GAP    = 2   // minimum SS_n-high cycles between frames, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] cmd_word,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL    = 3'd1,
        SHIFT  = 3'd2,
        TURN   = 3'd3,
        RECV   = 3'd4,
        GAP_ST = 3'd5
    } state_t;

    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Counter reload values hold "cycles remaining after this one".
    localparam logic [1:0] SEL_LOAD   = 2'd1;
    localparam logic [3:0] SHIFT_LOAD = 4'd9;
    localparam logic [3:0] TURN_LOAD  = 4'(RD_LAT - 1);
    localparam logic [3:0] RECV_LOAD  = 4'd7;
    localparam logic [3:0] GAP_LOAD   = 4'(GAP - 1);
    localparam logic       GAP_IS_ONE = (GAP == 1);

    state_t     state;
    logic [9:0] word;     // command latched at acceptance
    logic [8:0] tx_sh;    // payload bits still to be driven on MOSI
    logic [7:0] rx_sh;    // MISO bits collected so far, first sample ends up in bit 7
    logic [3:0] cnt;      // shared down-counter for SHIFT, TURN, RECV and GAP_ST
    logic [1:0] sel_cnt;  // select-preamble counter
    logic       pending;  // start taken in the done cycle; frame begins after one idle cycle
    logic       is_rd;

    assign is_rd = (word[9:8] == OP_RD_DATA);

    // Frame sequencer: state, counters, shift registers and every registered output
    always_ff @(posedge clk) begin
        // NOTE: rst_n is sampled on the clock edge like any other input, so it
        // does not belong in the sensitivity list.
        if (!rst_n) begin
            state         <= IDLE;
            word          <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            cnt           <= '0;
            sel_cnt       <= '0;
            pending       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rx_byte       <= 8'h00;
            rx_byte_valid <= 1'b0;
            SS_n          <= 1'b1;
            MOSI          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from last cycle's values regardless of statement order.
            done          <= 1'b0;
            rx_byte_valid <= 1'b0;

            case (state)
                IDLE: begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                    if (pending || start) begin
                        // A pending frame already holds its word; a fresh start latches it now.
                        if (!pending) begin
                            word <= cmd_word;
                        end
                        MOSI    <= pending ? word[9] : cmd_word[9];
                        SS_n    <= 1'b0;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                        sel_cnt <= SEL_LOAD;
                        state   <= SEL;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                SEL: begin
                    // MOSI keeps the command-select bit for both preamble cycles.
                    if (sel_cnt != 2'd0) begin
                        sel_cnt <= sel_cnt - 2'd1;
                    end else begin
                        MOSI  <= word[0];
                        tx_sh <= word[9:1];
                        cnt   <= SHIFT_LOAD;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cnt != 4'd0) begin
                        MOSI  <= tx_sh[0];
                        tx_sh <= {1'b0, tx_sh[8:1]};
                        cnt   <= cnt - 4'd1;
                    end else if (is_rd) begin
                        MOSI  <= 1'b0;
                        cnt   <= TURN_LOAD;
                        state <= TURN;
                    end else begin
                        SS_n  <= 1'b1;
                        MOSI  <= 1'b0;
                        cnt   <= GAP_LOAD;
                        done  <= GAP_IS_ONE;
                        state <= GAP_ST;
                    end
                end

                TURN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rx_sh <= '0;
                        cnt   <= RECV_LOAD;
                        state <= RECV;
                    end
                end

                RECV: begin
                    // MISO is taken at the end of every RECV cycle, MSB-first.
                    rx_sh <= {rx_sh[6:0], MISO};
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rx_byte       <= {rx_sh[6:0], MISO};
                        SS_n          <= 1'b1;
                        cnt           <= GAP_LOAD;
                        done          <= GAP_IS_ONE;
                        rx_byte_valid <= GAP_IS_ONE;
                        state         <= GAP_ST;
                    end
                end

                GAP_ST: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        // done is registered, so it is raised on the edge into the last gap cycle.
                        if (cnt == 4'd1) begin
                            done          <= 1'b1;
                            rx_byte_valid <= is_rd;
                        end
                    end else begin
                        // A start seen while done is high queues the next frame behind one
                        // extra idle cycle, keeping SS_n high for GAP+1 cycles.
                        state <= IDLE;
                        if (start) begin
                            word    <= cmd_word;
                            pending <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    SS_n    <= 1'b1;
                    MOSI    <= 1'b0;
                    busy    <= 1'b0;
                    cnt     <= '0;
                    sel_cnt <= '0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed table, corner-case sequences and random frames
// for spi_master, with a behavioural SPI slave + RAM and a frame monitor.
module tb_spi_master;

    localparam int RD_LAT = 3;
    localparam int GAP    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cmd_word = '0;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    spi_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cmd_word      (cmd_word),
        .busy          (busy),
        .done          (done),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .SS_n          (SS_n),
        .MOSI          (MOSI),
        .MISO          (MISO)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor + slave/RAM model ----------------
    typedef struct {
        int          len;
        logic [31:0] bits;
        int          gap_before;
    } frame_t;

    frame_t      frame_q[$];
    int          lo_pos = 0;
    int          hi_run = 0;
    int          gap_at_start = 0;
    logic [31:0] cur_bits = '0;
    logic        prev_ss = 1'b1;
    int          done_cnt = 0;
    int          rxv_cnt = 0;
    int          done_hi = 0;
    logic        done_ss = 1'b0;
    logic        done_rxv = 1'b0;

    logic [7:0]  s_mem [256];
    logic [7:0]  s_addr = '0;
    logic [7:0]  s_raddr = '0;
    logic [7:0]  s_rd_byte = '0;
    logic        s_rd_active = 1'b0;
    logic [9:0]  s_word;

    // Sample at negedge, away from the DUT's active edge; MISO is set here for the
    // cycle in progress so the master sees it at the next rising edge.
    always @(negedge clk) begin
        if (SS_n === 1'b0) begin
            if (prev_ss !== 1'b0) begin
                lo_pos       = 0;
                cur_bits     = '0;
                gap_at_start = hi_run;
                s_rd_active  = 1'b0;
            end
            hi_run = 0;
            if (lo_pos < 32) cur_bits[lo_pos] = MOSI;
            if (lo_pos == 11) begin
                s_word = cur_bits[11:2];
                case (s_word[9:8])
                    2'b00:   s_addr = s_word[7:0];
                    2'b01:   s_mem[s_addr] = s_word[7:0];
                    2'b10:   s_raddr = s_word[7:0];
                    default: begin
                        s_rd_byte   = s_mem[s_raddr];
                        s_rd_active = 1'b1;
                    end
                endcase
            end
            if (s_rd_active && lo_pos >= 12 + RD_LAT && lo_pos < 20 + RD_LAT)
                MISO = s_rd_byte[7 - (lo_pos - 12 - RD_LAT)];
            else
                MISO = 1'($urandom);
            lo_pos++;
        end else begin
            if (prev_ss === 1'b0) frame_q.push_back('{lo_pos, cur_bits, gap_at_start});
            hi_run++;
            MISO = 1'($urandom);
        end
        prev_ss = SS_n;
        if (done === 1'b1) begin
            done_cnt++;
            done_hi  = hi_run;
            done_ss  = SS_n;
            done_rxv = rx_byte_valid;
        end
        if (rx_byte_valid === 1'b1) rxv_cnt++;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] ref_addr = '0;
    logic [7:0] ref_raddr = '0;
    logic [7:0] ref_rx = '0;

    task automatic ref_apply(input logic [9:0] w);
        case (w[9:8])
            2'b00:   ref_addr = w[7:0];
            2'b01:   ref_mem[ref_addr] = w[7:0];
            2'b10:   ref_raddr = w[7:0];
            default: ref_rx = ref_mem[ref_raddr];
        endcase
    endtask

    // Expected MOSI over the low period: select bit twice, then the word LSB-first, then zeros.
    function automatic logic [31:0] exp_bits(input logic [9:0] w);
        logic [31:0] b;
        b    = '0;
        b[0] = w[9];
        b[1] = w[9];
        for (int i = 0; i < 10; i++) b[2 + i] = w[i];
        return b;
    endfunction

    function automatic int exp_len(input logic [9:0] w);
        return (w[9:8] == 2'b11) ? 20 + RD_LAT : 12;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy !== 1'b0; i++) tick();
        check({tag, ".idle"}, busy, 1'b0);
    endtask

    task automatic issue(input logic [9:0] w);
        start    = 1'b1;
        cmd_word = w;
        tick();
        start    = 1'b0;
        cmd_word = 10'($urandom);
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 200 && done_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, ".done_seen"}, (done_cnt > d0), 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [9:0] w, input int len,
                             input logic rxv, input logic [7:0] rx);
        frame_t f;
        int     d0;
        int     r0;
        wait_idle(tag);
        d0 = done_cnt;
        r0 = rxv_cnt;
        issue(w);
        wait_done(tag, d0);
        check({tag, ".busy_at_done"}, busy, 1'b1);
        check({tag, ".done_ss_high"}, done_ss, 1'b1);
        check({tag, ".done_gap_pos"}, done_hi, GAP);
        check({tag, ".rxv_with_done"}, done_rxv, rxv);
        check({tag, ".rx_byte"}, rx_byte, rx);
        check({tag, ".frame_count"}, frame_q.size(), 1);
        if (frame_q.size() > 0) begin
            f = frame_q.pop_front();
            check({tag, ".ss_low_len"}, f.len, len);
            check({tag, ".mosi"}, f.bits, exp_bits(w));
        end
        tick();
        check({tag, ".done_single"}, done, 1'b0);
        check({tag, ".busy_after"}, busy, 1'b0);
        check({tag, ".done_count"}, done_cnt - d0, 1);
        check({tag, ".rxv_count"}, rxv_cnt - r0, {31'd0, rxv});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [9:0] cmd;
        int         exp_len;
        logic       exp_rxv;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f1;
        frame_t f2;
        int     d0;

        for (int i = 0; i < 256; i++) begin
            s_mem[i]   = 8'h00;
            ref_mem[i] = 8'h00;
        end
        s_mem[0]   = 8'hB6;
        ref_mem[0] = 8'hB6;

        tbl[0] = '{10'h0A5, 12,          1'b0, 8'h00};
        tbl[1] = '{10'h3C0, 20 + RD_LAT, 1'b1, 8'hB6};
        tbl[2] = '{10'h010, 12,          1'b0, 8'hB6};
        tbl[3] = '{10'h17E, 12,          1'b0, 8'hB6};
        tbl[4] = '{10'h210, 12,          1'b0, 8'hB6};
        tbl[5] = '{10'h300, 20 + RD_LAT, 1'b1, 8'h7E};

        // Reset, with start held high to show it is discarded.
        rst_n    = 1'b0;
        start    = 1'b1;
        cmd_word = 10'h3FF;
        repeat (3) tick();
        check("reset.ss_n", SS_n, 1'b1);
        check("reset.mosi", MOSI, 1'b0);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.rxv", rx_byte_valid, 1'b0);
        check("reset.rx_byte", rx_byte, 8'h00);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("reset.start_discarded.busy", busy, 1'b0);
        check("reset.start_discarded.ss_n", SS_n, 1'b1);

        for (int i = 0; i < 6; i++) begin
            ref_apply(tbl[i].cmd);
            run_frame($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].exp_len, tbl[i].exp_rxv, tbl[i].exp_rx);
        end

        // start during a frame with a different word is ignored.
        wait_idle("ignore");
        d0 = done_cnt;
        issue(10'h155);
        ref_apply(10'h155);
        repeat (5) tick();
        start    = 1'b1;
        cmd_word = 10'h2AA;
        tick();
        start    = 1'b0;
        wait_done("ignore", d0);
        check("ignore.frame_count", frame_q.size(), 1);
        if (frame_q.size() > 0) begin
            f1 = frame_q.pop_front();
            check("ignore.mosi", f1.bits, exp_bits(10'h155));
        end
        repeat (40) tick();
        check("ignore.done_count", done_cnt - d0, 1);
        check("ignore.no_extra_frame", frame_q.size(), 0);

        // Back-to-back: second start presented in the done cycle.
        wait_idle("b2b");
        d0 = done_cnt;
        issue(10'h155);
        ref_apply(10'h155);
        wait_done("b2b.first", d0);
        start    = 1'b1;
        cmd_word = 10'h2AA;
        tick();
        start    = 1'b0;
        cmd_word = 10'($urandom);
        ref_apply(10'h2AA);
        wait_done("b2b.second", d0 + 1);
        check("b2b.frame_count", frame_q.size(), 2);
        if (frame_q.size() >= 2) begin
            f1 = frame_q.pop_front();
            f2 = frame_q.pop_front();
            check("b2b.first.mosi", f1.bits, exp_bits(10'h155));
            check("b2b.first.len", f1.len, 12);
            check("b2b.second.mosi", f2.bits, exp_bits(10'h2AA));
            check("b2b.second.len", f2.len, 12);
            check("b2b.gap_ge_gap_plus_1", (f2.gap_before >= GAP + 1), 1'b1);
        end
        repeat (3) tick();

        // Reset in the middle of RECV of a rd-data frame.
        wait_idle("rst_mid");
        d0 = done_cnt;
        issue(10'h300);
        repeat (16) tick();
        check("rst_mid.in_frame", SS_n, 1'b0);
        rst_n = 1'b0;
        tick();
        check("rst_mid.ss_n", SS_n, 1'b1);
        check("rst_mid.busy", busy, 1'b0);
        check("rst_mid.rx_byte", rx_byte, 8'h00);
        check("rst_mid.done", done, 1'b0);
        check("rst_mid.rxv", rx_byte_valid, 1'b0);
        check("rst_mid.mosi", MOSI, 1'b0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("rst_mid.no_done", done_cnt - d0, 0);
        frame_q.delete();
        ref_rx = 8'h00;
        ref_apply(10'h300);
        run_frame("rst_mid.reread", 10'h300, 20 + RD_LAT, 1'b1, ref_rx);

        // Random frames against the reference model.
        for (int k = 0; k < 30; k++) begin
            logic [1:0] op;
            logic [7:0] d;
            logic [9:0] w;
            op = 2'($urandom_range(0, 3));
            d  = (op == 2'b00 || op == 2'b10) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            w  = {op, d};
            ref_apply(w);
            repeat ($urandom_range(0, 3)) tick();
            run_frame($sformatf("rnd%0d", k), w, exp_len(w), (op == 2'b11), ref_rx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
